// File: rtl/seq_code_pkg.sv
// Shared types and constants for the serial unlock-code transmitter.
package seq_code_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} tx_state_t;

  localparam int          CODE_LEN_DEF   = 11;
  localparam logic [10:0] UNLOCK_CODE    = 11'b000_1001_0100;
  localparam logic        IDLE_LEVEL_DEF = 1'b0;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_code_piso.sv
// Parallel-in serial-out shift register; the MSB is the bit currently on the line.
module seq_code_piso #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/seq_code_tx.sv
// Serial unlock-code transmitter: sends a code word MSB-first, optionally repeated with
// an idle gap between frames, with start/ready handshake, abort and status pulses.
module seq_code_tx
  import seq_code_pkg::*;
#(
  parameter int   CODE_LEN   = CODE_LEN_DEF,
  parameter int   GAP_CYCLES = 4,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF,
  parameter int   REPEAT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CODE_LEN-1:0] code_i,
  input  logic [REPEAT_W-1:0] repeat_i,
  input  logic                abort_i,
  output logic                tx_o,
  output logic                tx_en_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam int BIT_W = cnt_width(CODE_LEN);
  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_INIT = BIT_W'(CODE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t           state;
  tx_state_t           state_next;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [REPEAT_W-1:0] frames_left;
  logic [CODE_LEN-1:0] shadow;
  logic [CODE_LEN-1:0] load_data;
  logic                accept;
  logic                abort_hit;
  logic                frame_end;
  logic                gap_end;
  logic                reload;
  logic                msb;
  logic                aborted_q;

  assign accept    = (state == IDLE) && start_i && !abort_i;
  assign abort_hit = ((state == SHIFT) || (state == GAP)) && abort_i;
  assign frame_end = (state == SHIFT) && (bit_cnt == '0);
  assign gap_end   = (state == GAP) && (gap_cnt == '0);
  // The next frame starts either straight after the last bit or after the gap expires.
  assign reload    = !abort_hit && (frames_left != '0) &&
                     ((GAP_CYCLES == 0) ? frame_end : gap_end);
  assign load_data = (state == IDLE) ? code_i : shadow;

  seq_code_piso #(
    .WIDTH(CODE_LEN)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (accept || reload),
    .shift_en(state == SHIFT),
    .data    (load_data),
    .msb     (msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (frame_end) begin
          if (GAP_CYCLES > 0)          state_next = GAP;
          else if (frames_left != '0)  state_next = SHIFT;
          else                         state_next = DONE;
        end
      end
      GAP: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (gap_end) begin
          state_next = (frames_left != '0) ? SHIFT : DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frames_left <= '0;
      shadow      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
      if (accept) begin
        shadow      <= code_i;
        frames_left <= (repeat_i == '0) ? '0 : repeat_i - 1'b1;
        bit_cnt     <= BIT_INIT;
      end
      if (state == SHIFT) begin
        bit_cnt <= frame_end ? BIT_INIT : bit_cnt - 1'b1;
      end
      if (frame_end) begin
        gap_cnt <= GAP_INIT;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (reload) begin
        frames_left <= frames_left - 1'b1;
      end
    end
  end

  always_comb begin
    tx_o    = IDLE_LEVEL;
    tx_en_o = 1'b0;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state)
      IDLE:  ready_o = 1'b1;
      SHIFT: begin
        tx_o    = msb;
        tx_en_o = 1'b1;
        busy_o  = 1'b1;
      end
      GAP:   busy_o = 1'b1;
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ready_o = 1'b0;
    endcase
  end

  assign aborted_o = aborted_q;

endmodule

// File: tb/tb_seq_code_tx.sv
// Directed self-checking bench for seq_code_tx (default build plus a zero-gap build).
module tb_seq_code_tx;
  import seq_code_pkg::*;

  localparam logic [10:0] CODE_A = UNLOCK_CODE;
  localparam logic [10:0] CODE_B = 11'b101_1001_1101;
  localparam logic [10:0] CODE_C = 11'b111_0000_1111;

  logic        clk;
  logic        rst;
  logic        start_i, abort_i;
  logic [10:0] code_i;
  logic [3:0]  repeat_i;
  logic        tx_o, tx_en_o, ready_o, busy_o, done_o, aborted_o;

  logic        start0, abort0;
  logic [10:0] code0;
  logic [3:0]  repeat0;
  logic        tx0, tx_en0, ready0, busy0, done0, aborted0;

  int checks = 0;
  int errors = 0;

  seq_code_tx dut (
    .clk(clk), .rst(rst), .start_i(start_i), .code_i(code_i), .repeat_i(repeat_i),
    .abort_i(abort_i), .tx_o(tx_o), .tx_en_o(tx_en_o), .ready_o(ready_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  seq_code_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .code_i(code0), .repeat_i(repeat0),
    .abort_i(abort0), .tx_o(tx0), .tx_en_o(tx_en0), .ready_o(ready0),
    .busy_o(busy0), .done_o(done0), .aborted_o(aborted0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic start, input logic [10:0] code,
                               input logic [3:0] rep, input logic abort);
    start_i  = start;
    code_i   = code;
    repeat_i = rep;
    abort_i  = abort;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bits first..last of a frame; optionally pulses start with a different code at bit poke.
  task automatic expectBits(input logic [10:0] code, input int first, input int last,
                            input int poke);
    for (int i = first; i <= last; i++) begin
      checkOutput("tx_bit", {31'd0, tx_o}, {31'd0, code[10-i]});
      checkOutput("tx_en", {31'd0, tx_en_o}, 32'd1);
      checkOutput("busy_shift", {31'd0, busy_o}, 32'd1);
      applyStimulus(i == poke, CODE_C, 4'd9, 1'b0);
      tick();
    end
  endtask

  task automatic expectGap(input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      checkOutput("gap_tx_en", {31'd0, tx_en_o}, 32'd0);
      checkOutput("gap_tx", {31'd0, tx_o}, {31'd0, IDLE_LEVEL_DEF});
      checkOutput("gap_busy", {31'd0, busy_o}, 32'd1);
      checkOutput("gap_done", {31'd0, done_o}, 32'd0);
      applyStimulus(i == poke, CODE_C, 4'd9, 1'b0);
      tick();
    end
  endtask

  task automatic expectDone(input logic abort_in);
    checkOutput("done_pulse", {31'd0, done_o}, 32'd1);
    checkOutput("done_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("done_tx_en", {31'd0, tx_en_o}, 32'd0);
    applyStimulus(1'b0, CODE_C, 4'd9, abort_in);
    tick();
    applyStimulus(1'b0, CODE_C, 4'd9, 1'b0);
    checkOutput("post_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("post_done", {31'd0, done_o}, 32'd0);
    checkOutput("post_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("post_aborted", {31'd0, aborted_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    start0 = 1'b0; abort0 = 1'b0; code0 = '0; repeat0 = '0;
    tick();
    checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_tx_en", {31'd0, tx_en_o}, 32'd0);
    checkOutput("rst_tx", {31'd0, tx_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_aborted", {31'd0, aborted_o}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single unlock frame");
    applyStimulus(1'b1, CODE_A, 4'd1, 1'b0);
    tick();
    expectBits(CODE_A, 0, 10, -1);
    expectGap(4, -1);
    expectDone(1'b0);
    tick();

    $display("[TB] repeat=0 acts as one frame");
    applyStimulus(1'b1, CODE_B, 4'd0, 1'b0);
    tick();
    expectBits(CODE_B, 0, 10, -1);
    expectGap(4, -1);
    expectDone(1'b0);

    $display("[TB] start while busy ignored, two frames, abort in DONE ignored");
    applyStimulus(1'b1, CODE_A, 4'd2, 1'b0);
    tick();
    expectBits(CODE_A, 0, 10, 3);
    expectGap(4, 1);
    expectBits(CODE_A, 0, 10, 7);
    expectGap(4, 2);
    expectDone(1'b1);

    $display("[TB] abort at bit 5 then restart");
    applyStimulus(1'b1, CODE_B, 4'd3, 1'b0);
    tick();
    expectBits(CODE_B, 0, 4, -1);
    checkOutput("abort_bit5", {31'd0, tx_o}, {31'd0, CODE_B[5]});
    applyStimulus(1'b0, CODE_C, 4'd9, 1'b1);
    tick();
    applyStimulus(1'b0, CODE_C, 4'd9, 1'b0);
    checkOutput("abort_tx_en", {31'd0, tx_en_o}, 32'd0);
    checkOutput("abort_tx", {31'd0, tx_o}, 32'd0);
    checkOutput("abort_pulse", {31'd0, aborted_o}, 32'd1);
    checkOutput("abort_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("abort_done", {31'd0, done_o}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("abort_after_pulse", {31'd0, aborted_o}, 32'd0);
      checkOutput("abort_no_done", {31'd0, done_o}, 32'd0);
      checkOutput("abort_idle", {31'd0, tx_en_o}, 32'd0);
      tick();
    end
    applyStimulus(1'b1, CODE_C, 4'd1, 1'b0);
    tick();
    expectBits(CODE_C, 0, 10, -1);
    expectGap(4, -1);
    expectDone(1'b0);

    $display("[TB] zero-gap build, three back-to-back frames");
    start0 = 1'b1; code0 = CODE_A; repeat0 = 4'd3;
    tick();
    start0 = 1'b0; code0 = CODE_C;
    for (int i = 0; i < 33; i++) begin
      checkOutput("g0_tx_en", {31'd0, tx_en0}, 32'd1);
      checkOutput("g0_bit", {31'd0, tx0}, {31'd0, CODE_A[10 - (i % 11)]});
      checkOutput("g0_done", {31'd0, done0}, 32'd0);
      tick();
    end
    checkOutput("g0_done_pulse", {31'd0, done0}, 32'd1);
    checkOutput("g0_done_tx_en", {31'd0, tx_en0}, 32'd0);
    tick();
    checkOutput("g0_ready", {31'd0, ready0}, 32'd1);
    checkOutput("g0_done_end", {31'd0, done0}, 32'd0);

    $display("[TB] async reset mid-frame");
    applyStimulus(1'b1, CODE_B, 4'd2, 1'b0);
    tick();
    expectBits(CODE_B, 0, 2, -1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_tx_en", {31'd0, tx_en_o}, 32'd0);
    checkOutput("arst_tx", {31'd0, tx_o}, 32'd0);
    checkOutput("arst_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("arst_stays_idle", {31'd0, tx_en_o}, 32'd0);
    checkOutput("arst_no_done", {31'd0, done_o}, 32'd0);
    checkOutput("arst_no_abort", {31'd0, aborted_o}, 32'd0);

    $display("[TB] start and abort together in IDLE");
    applyStimulus(1'b1, CODE_A, 4'd1, 1'b1);
    tick();
    applyStimulus(1'b0, CODE_A, 4'd1, 1'b0);
    checkOutput("sa_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("sa_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("sa_aborted", {31'd0, aborted_o}, 32'd0);
    tick();
    checkOutput("sa_tx_en", {31'd0, tx_en_o}, 32'd0);
    checkOutput("sa_done", {31'd0, done_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
